// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate back end: sums K signed products per frame
// and presents the clamped frame sum on a held valid/ready output.
module mac_accumulator #(
    parameter int unsigned N     = 5,
    parameter int unsigned K     = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*N-1:0]             product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           result,
    output logic                       ovf,
    output logic [$clog2(K+1)-1:0]     count
);

    localparam int unsigned PROD_W = 2 * N;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = $clog2(K + 1);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(K - 1);

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               first;
    logic [SUM_W-1:0]   p_ext;
    logic [SUM_W-1:0]   acc_ext;
    logic [SUM_W-1:0]   sum;
    logic               pos_sat;
    logic               neg_sat;
    logic [ACC_W-1:0]   sat_val;

    // One guard bit above ACC_W is enough: both addends fit in ACC_W bits.
    always_comb begin
        first   = (count_q == '0);
        p_ext   = {{(SUM_W-PROD_W){product[PROD_W-1]}}, product};
        acc_ext = {acc_q[ACC_W-1], acc_q};
        sum     = first ? p_ext : (acc_ext + p_ext);
        pos_sat = ~sum[SUM_W-1] &  sum[SUM_W-2];
        neg_sat =  sum[SUM_W-1] & ~sum[SUM_W-2];
        if (pos_sat) begin
            sat_val = ACC_MAX;
        end else if (neg_sat) begin
            sat_val = ACC_MIN;
        end else begin
            sat_val = sum[ACC_W-1:0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        accept   = 1'b0;

        case (state_q)
            S_ACC: begin
                accept = in_valid;
                if (accept) begin
                    acc_d = sat_val;
                    ovf_d = (first ? 1'b0 : ovf_q) | pos_sat | neg_sat;
                    if (count_q == LAST) begin
                        count_d  = '0;
                        result_d = sat_val;
                        state_d  = S_HOLD;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_HOLD);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: three configurations checked every cycle
// against an integer frame-sum model, plus hand-computed literal expectations.
module tb_mac_accumulator;

    localparam int KS[3] = '{4, 4, 1};
    localparam int WS[3] = '{12, 10, 10};

    logic clk;
    logic rst;
    logic chk_en;

    logic iv[3];
    logic ordy[3];
    int   pv[3];

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [11:0] res0;
    logic [9:0]  res1, res2;
    logic [2:0]  cnt0, cnt1;
    logic [0:0]  cnt2;

    logic a_ov[3], a_ir[3], a_ovf[3];
    int   a_res[3], a_cnt[3];

    logic m_hold[3], m_ovf[3];
    int   m_acc[3], m_cnt[3], m_res[3];

    int nchecks;
    int nerr;

    int gv[7] = '{1, 0, 0, 1, 1, 0, 1};
    int gp[7] = '{10, 99, -99, -20, 33, 77, -5};

    mac_accumulator #(.N(5), .K(4), .ACC_W(12)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .product(10'(pv[0])), .out_valid(ov0), .out_ready(ordy[0]),
        .result(res0), .ovf(of0), .count(cnt0)
    );

    mac_accumulator #(.N(5), .K(4), .ACC_W(10)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .product(10'(pv[1])), .out_valid(ov1), .out_ready(ordy[1]),
        .result(res1), .ovf(of1), .count(cnt1)
    );

    mac_accumulator #(.N(5), .K(1), .ACC_W(10)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .product(10'(pv[2])), .out_valid(ov2), .out_ready(ordy[2]),
        .result(res2), .ovf(of2), .count(cnt2)
    );

    assign a_ov[0] = ov0;  assign a_ov[1] = ov1;  assign a_ov[2] = ov2;
    assign a_ir[0] = ir0;  assign a_ir[1] = ir1;  assign a_ir[2] = ir2;
    assign a_ovf[0] = of0; assign a_ovf[1] = of1; assign a_ovf[2] = of2;
    assign a_res[0] = int'($signed(res0));
    assign a_res[1] = int'($signed(res1));
    assign a_res[2] = int'($signed(res2));
    assign a_cnt[0] = int'(cnt0);
    assign a_cnt[1] = int'(cnt1);
    assign a_cnt[2] = int'(cnt2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampw(input int s, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Frame-level model: running clamped sum, sticky overflow, K-term frames.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int s;
            int c;
            if (rst) begin
                m_hold[i] <= 1'b0;
                m_acc[i]  <= 0;
                m_cnt[i]  <= 0;
                m_ovf[i]  <= 1'b0;
                m_res[i]  <= 0;
            end else if (m_hold[i]) begin
                if (ordy[i]) m_hold[i] <= 1'b0;
            end else if (iv[i]) begin
                s = (m_cnt[i] == 0) ? pv[i] : (m_acc[i] + pv[i]);
                c = clampw(s, WS[i]);
                m_acc[i] <= c;
                m_ovf[i] <= ((m_cnt[i] == 0) ? 1'b0 : m_ovf[i]) | (c != s);
                if (m_cnt[i] + 1 == KS[i]) begin
                    m_cnt[i]  <= 0;
                    m_hold[i] <= 1'b1;
                    m_res[i]  <= c;
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_out_valid", i), int'(a_ov[i]), int'(m_hold[i]));
                check($sformatf("u%0d_in_ready", i), int'(a_ir[i]), int'(!m_hold[i]));
                check($sformatf("u%0d_result", i), a_res[i], m_res[i]);
                check($sformatf("u%0d_ovf", i), int'(a_ovf[i]), int'(m_ovf[i]));
                check($sformatf("u%0d_count", i), a_cnt[i], m_cnt[i]);
            end
        end
    end

    task automatic drive(input int i, input logic v, input int p, input logic r);
        iv[i]   = v;
        pv[i]   = p;
        ordy[i] = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Literal expectations applied to both the DUT and the model.
    task automatic lit(input string nm, input int i, input int e_ov, input int e_res,
                       input int e_ovf, input int e_cnt);
        check({nm, "_dut_ov"},  int'(a_ov[i]), e_ov);
        check({nm, "_dut_ir"},  int'(a_ir[i]), 1 - e_ov);
        check({nm, "_dut_res"}, a_res[i], e_res);
        check({nm, "_dut_ovf"}, int'(a_ovf[i]), e_ovf);
        check({nm, "_dut_cnt"}, a_cnt[i], e_cnt);
        check({nm, "_mdl_res"}, m_res[i], e_res);
        check({nm, "_mdl_ovf"}, int'(m_ovf[i]), e_ovf);
        check({nm, "_mdl_cnt"}, m_cnt[i], e_cnt);
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 0, 1'b0);
        tick();
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) lit($sformatf("reset%0d", i), i, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset while u0 holds a result and u1 is two products into a frame.
        drive(0, 1'b1, 1, 1'b0); drive(1, 1'b1, 5, 1'b0); tick();
        drive(0, 1'b1, 2, 1'b0); drive(1, 1'b1, 6, 1'b0); tick();
        drive(0, 1'b1, 3, 1'b0); drive(1, 1'b0, 0, 1'b0); tick();
        drive(0, 1'b1, 4, 1'b0); tick();
        lit("pre_hold", 0, 1, 10, 0, 0);
        lit("pre_mid", 1, 0, 0, 0, 2);
        rst = 1'b1;
        drive(0, 1'b1, 9, 1'b1); drive(1, 1'b1, 9, 1'b0); tick();
        rst = 1'b0;
        drive(0, 1'b0, 0, 1'b0); drive(1, 1'b0, 0, 1'b0);
        lit("mid_rst0", 0, 0, 0, 0, 0);
        lit("mid_rst1", 1, 0, 0, 0, 0);

        // Plain dot product, consumer always ready.
        drive(0, 1'b1, 30, 1'b1);  tick();
        drive(0, 1'b1, -45, 1'b1); tick();
        drive(0, 1'b1, 100, 1'b1); tick();
        drive(0, 1'b1, 7, 1'b1);   tick();
        lit("dot", 0, 1, 92, 0, 0);
        drive(0, 1'b0, 0, 1'b1);   tick();
        lit("dot_rel", 0, 0, 92, 0, 0);
        drive(0, 1'b0, 0, 1'b0);

        // Positive saturation, then ovf clearing and per-addition clamping.
        drive(1, 1'b1, 256, 1'b1); tick();
        lit("sat1", 1, 0, 0, 0, 1);
        tick();
        lit("sat2", 1, 0, 0, 1, 2);
        tick();
        tick();
        lit("sat", 1, 1, 511, 1, 0);
        drive(1, 1'b0, 0, 1'b1);    tick();
        drive(1, 1'b1, -256, 1'b1); tick();
        lit("clr", 1, 0, 511, 0, 1);
        tick();
        drive(1, 1'b1, 10, 1'b1);   tick();
        drive(1, 1'b1, 0, 1'b1);    tick();
        lit("neg", 1, 1, -502, 0, 0);
        drive(1, 1'b0, 0, 1'b1);    tick();
        drive(1, 1'b1, -512, 1'b1); tick();
        tick();
        drive(1, 1'b1, 300, 1'b1);  tick();
        drive(1, 1'b1, 0, 1'b1);    tick();
        lit("nsat", 1, 1, -212, 1, 0);
        drive(1, 1'b0, 0, 1'b1);    tick();
        drive(1, 1'b0, 0, 1'b0);

        // Output backpressure with the producer still asserting.
        drive(0, 1'b1, 1, 1'b0);
        repeat (4) tick();
        lit("bp_hold", 0, 1, 4, 0, 0);
        for (int j = 0; j < 5; j++) begin
            drive(0, 1'b1, 50, 1'b0);
            tick();
            lit($sformatf("bp%0d", j), 0, 1, 4, 0, 0);
        end
        drive(0, 1'b1, 50, 1'b1); tick();
        lit("bp_rel", 0, 0, 4, 0, 0);
        tick();
        lit("bp_acc", 0, 0, 4, 0, 1);
        drive(0, 1'b1, 50, 1'b0);
        repeat (3) tick();
        lit("bp_done", 0, 1, 200, 0, 0);
        drive(0, 1'b0, 0, 1'b1); tick();
        drive(0, 1'b0, 0, 1'b0);

        // Gaps in in_valid: junk products while invalid must be ignored.
        for (int j = 0; j < 7; j++) begin
            drive(0, gv[j] != 0, gp[j], 1'b0);
            tick();
            if (j == 2) lit("gap", 0, 0, 200, 0, 1);
        end
        lit("gap_sum", 0, 1, 18, 0, 0);
        drive(0, 1'b0, 0, 1'b1); tick();
        drive(0, 1'b0, 0, 1'b0);

        // Single-product frames.
        drive(2, 1'b1, -512, 1'b0); tick();
        lit("k1", 2, 1, -512, 0, 0);
        drive(2, 1'b0, 0, 1'b1);    tick();
        drive(2, 1'b1, 511, 1'b1);  tick();
        lit("k1b", 2, 1, 511, 0, 0);
        drive(2, 1'b1, -7, 1'b1);   tick();
        lit("k1c", 2, 0, 511, 0, 0);
        tick();
        lit("k1d", 2, 1, -7, 0, 0);
        drive(2, 1'b0, 0, 1'b1);    tick();
        drive(2, 1'b0, 0, 1'b0);    tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

- Sequential multiply-accumulate back end that sits directly downstream of the combinational `multiplier` (N-bit signed operands, 2N-bit signed product).
- Accepts one signed product per valid/ready handshake and sign-extends it into a saturating accumulator.
- After K accepted products, presents the frame sum (a K-term dot product) on a held valid/ready output.
- Used wherever the datapath needs inner products built from the shared array multiplier.

## Interface

- `N`, default 5: multiplier operand width; the product input is 2N bits.
- `K`, default 4: products per frame; K ≥ 1.
- `ACC_W`, default 12: accumulator/result width; ACC_W ≥ 2N.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `in_valid` input 1: `product` is valid this cycle.
- `in_ready` output 1: block can accept a product.
- `product` input 2N: signed two's-complement product from `multiplier.out`.
- `out_valid` output 1: `result` and `ovf` hold a completed frame.
- `out_ready` input 1: consumer accepts the result.
- `result` output ACC_W: signed saturated frame sum.
- `ovf` output 1: saturation occurred at least once during the frame.
- `count` output clog2(K+1): products accepted in the current frame.

## Operation

- States:
  - `ACC` (collecting): `out_valid`=0, `in_ready`=1.
  - `HOLD` (result presented): `out_valid`=1, `in_ready`=0.
- `in_ready` is combinational, equal to !`out_valid`. The block never accepts an input while holding a result.
- Accept: `in_valid` && `in_ready` at a rising edge.
  - `p` = `product` sign-extended to ACC_W+1 bits.
  - If `count`==0: `sum` = `p`. Otherwise `sum` = sign-extended `acc` + `p`, computed at ACC_W+1 bits.
  - If `sum` > 2^(ACC_W-1)-1: `acc` becomes 2^(ACC_W-1)-1 and `ovf` is set.
  - If `sum` < -2^(ACC_W-1): `acc` becomes -2^(ACC_W-1) and `ovf` is set.
  - Otherwise `acc` becomes `sum`.
  - `ovf` is sticky within a frame. It is cleared when the first product of the next frame is accepted.
  - `count` increments on each accept.
- Frame end: on the accept that makes `count`==K:
  - Transition to `HOLD`.
  - `result` = the final saturated `acc`; `count` returns to 0.
- `HOLD`:
  - `result` and `ovf` stay stable.
  - Leave on `out_ready`=1, returning to `ACC`.
  - `in_valid` is ignored while in `HOLD`.
- `out_ready` is ignored in `ACC`.
- Saturation applies per addition, not only to the final sum. A later product of opposite sign subtracts from the clamped value.
- K=1: every accepted product goes directly to `HOLD` with `result` = saturated `product`.

## Timing

- Reset values: `out_valid`=0, `in_ready`=1 (after the reset edge), `result`=0, `ovf`=0, `count`=0, `acc`=0; state `ACC`.
- `rst` overrides everything, including a handshake or `out_ready` in the same cycle. A partial frame is discarded and a held result is dropped.
- Latency:
  - K-th accept at edge t gives `out_valid`=1 in the cycle after edge t.
  - Consumer handshake at edge t+m gives `in_ready`=1 in the cycle after that edge.
- Throughput: one product per cycle while collecting. Each frame costs K cycles plus at least one `HOLD` cycle, since handshakes do not overlap.
- `in_valid` dropped mid-frame: `acc` and `count` hold indefinitely; there is no timeout.
- `in_valid` and `out_ready` both high in `HOLD`: only the output handshake occurs. The product is not consumed, and the producer must keep it asserted.
- No combinational path from `product` to any output. `in_ready` depends only on state.

## Test plan

- Reset with `out_valid` high and `count`=2 mid-frame → next cycle `out_valid`=0, `count`=0, `result`=0, `ovf`=0, `in_ready`=1.
- N=5, K=4, ACC_W=12, products 30, -45, 100, 7 back-to-back, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `result`=92, `ovf`=0, `in_ready` high again the following cycle.
- ACC_W=10, products 256, 256, 256, 256 → clamp at 511 from the 2nd add onward; `result`=511, `ovf`=1.
- Next frame in the same configuration, products -256, -256, 10, 0 → `result`=-502, `ovf`=0. This checks that `ovf` clears and that saturation is per addition.
- Output backpressure: `out_ready`=0 for 5 cycles with `in_valid` held high → `result` stable, `in_ready`=0, no product consumed. When `out_ready` rises, the next product is accepted one cycle later.
- Gaps and K=1:
  - K=4 with `in_valid` toggling 1,0,0,1,1,0,1 → `count` advances only on accepts, and the sum is correct.
  - K=1 with product -512 at ACC_W=10 → `result`=-512, `ovf`=0.
